// File: rtl/tmds_video_sequencer_if.sv
// Pixel-source handshake between the frame source and the TMDS raster sequencer.
// The source drives valid and data, and the sequencer answers with ready.
interface tmds_video_sequencer_if;
    logic        i_pix_valid;
    logic [23:0] i_pix_rgb;
    logic        o_pix_ready;

    modport master (output i_pix_valid, output i_pix_rgb, input o_pix_ready);
    modport slave  (input i_pix_valid, input i_pix_rgb, output o_pix_ready);
endinterface

// File: rtl/tmds_video_sequencer.sv
// Raster timing for the three TMDS encoder channels: counters, sync, video enable,
// and a never-stalling pixel request toward the source.
module tmds_video_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_enable,
    input  logic                         i_clr_underflow,
    tmds_video_sequencer_if.slave        pix,
    output logic [11:0]                  o_x,
    output logic [11:0]                  o_y,
    output logic                         o_frame_start,
    output logic                         o_ve,
    output logic [7:0]                   o_red,
    output logic [7:0]                   o_green,
    output logic [7:0]                   o_blue,
    output logic [1:0]                   o_ctrl_b,
    output logic [1:0]                   o_ctrl_g,
    output logic [1:0]                   o_ctrl_r,
    output logic                         o_underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Region bounds are 13 bits so a 4096-wide total still compares correctly.
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [11:0] r_h;
    logic [11:0] r_v;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_fs;
    logic        r_ve;
    logic [23:0] r_rgb;
    logic [1:0]  r_ctrl_b;
    logic        r_uf;

    logic [12:0] w_h13;
    logic [12:0] w_v13;
    logic        w_on;
    logic        w_ready;
    logic        w_take;
    logic        w_hs;
    logic        w_vs;
    logic        w_last;

    assign w_h13   = {1'b0, r_h};
    assign w_v13   = {1'b0, r_v};
    assign w_on    = (r_state != S_IDLE);
    assign w_ready = w_on && (w_h13 < H_ACT) && (w_v13 < V_ACT);
    assign w_take  = w_ready && pix.i_pix_valid;
    assign w_hs    = w_on && (w_h13 >= HS_BEG) && (w_h13 < HS_END);
    assign w_vs    = w_on && (w_v13 >= VS_BEG) && (w_v13 < VS_END);
    assign w_last  = (r_h == H_LAST) && (r_v == V_LAST);

    assign pix.o_pix_ready = w_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_h      <= '0;
            r_v      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_fs     <= 1'b0;
            r_ve     <= 1'b0;
            r_rgb    <= '0;
            r_ctrl_b <= {~VS_POL, ~HS_POL};
            r_uf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_h <= '0;
                    r_v <= '0;
                    if (i_enable) r_state <= S_RUN;
                end
                S_RUN, S_DRAIN: begin
                    if (r_h == H_LAST) begin
                        r_h <= '0;
                        r_v <= (r_v == V_LAST) ? 12'd0 : r_v + 12'd1;
                    end else begin
                        r_h <= r_h + 12'd1;
                    end
                    // Disabling only takes effect at the frame boundary; the counters
                    // wrap to (0,0) on that same edge, so IDLE starts clean.
                    if (i_enable)    r_state <= S_RUN;
                    else if (w_last) r_state <= S_IDLE;
                    else             r_state <= S_DRAIN;
                end
                default: r_state <= S_IDLE;
            endcase

            r_x      <= r_h;
            r_y      <= r_v;
            r_fs     <= w_on && (r_h == 12'd0) && (r_v == 12'd0);
            r_ve     <= w_ready;
            r_rgb    <= w_take ? pix.i_pix_rgb : 24'd0;
            r_ctrl_b <= {(w_vs ? VS_POL : ~VS_POL), (w_hs ? HS_POL : ~HS_POL)};

            // A fresh miss outranks a clear request in the same cycle.
            if (w_ready && !pix.i_pix_valid) r_uf <= 1'b1;
            else if (i_clr_underflow)        r_uf <= 1'b0;
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_fs;
    assign o_ve          = r_ve;
    assign o_red         = r_rgb[23:16];
    assign o_green       = r_rgb[15:8];
    assign o_blue        = r_rgb[7:0];
    assign o_ctrl_b      = r_ctrl_b;
    assign o_ctrl_g      = 2'b00;
    assign o_ctrl_r      = 2'b00;
    assign o_underflow   = r_uf;

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Randomized bench for tmds_video_sequencer on a tiny 8x5 raster, checked against a
// frame-position model (linear cycle index within the frame plus an on/off flag).
module tb_tmds_video_sequencer;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [57:0] RST_VEC = {2'b00, 2'b11, 54'd0};

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
    logic [11:0] o_x, o_y;
    logic o_fs, o_ve, o_uf;
    logic [7:0] o_r, o_g, o_b;
    logic [1:0] o_cb, o_cg, o_cr;

    tmds_video_sequencer_if pif();

    tmds_video_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_clr_underflow(clr),
        .pix(pif),
        .o_x(o_x), .o_y(o_y), .o_frame_start(o_fs), .o_ve(o_ve),
        .o_red(o_r), .o_green(o_g), .o_blue(o_b),
        .o_ctrl_b(o_cb), .o_ctrl_g(o_cg), .o_ctrl_r(o_cr),
        .o_underflow(o_uf)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0, cyc = 0;
    bit m_on;
    int m_pos;
    bit m_uf;
    logic [57:0] exp_vec;

    function automatic logic [57:0] obs();
        return {o_ve, o_fs, o_cb, o_cg, o_cr, o_x, o_y, o_r, o_g, o_b, o_uf, pif.o_pix_ready};
    endfunction

    // One clock of the model: outputs for the current position, then advance.
    // The frame restarts unless enable is low on its final cycle.
    task automatic tick();
        int h, v;
        bit rdy, e_hs, e_vs, e_fs, nrdy;
        logic [23:0] e_rgb;
        h     = m_pos % HT;
        v     = m_pos / HT;
        rdy   = m_on && (h < HA) && (v < VA);
        e_rgb = (rdy && pif.i_pix_valid) ? pif.i_pix_rgb : 24'd0;
        e_fs  = m_on && (m_pos == 0);
        e_hs  = m_on && (h >= HA + HF) && (h < HA + HF + HS);
        e_vs  = m_on && (v >= VA + VF) && (v < VA + VF + VS);
        if (rdy && !pif.i_pix_valid) m_uf = 1'b1;
        else if (clr)                m_uf = 1'b0;
        if (m_on) begin
            if (m_pos == FT - 1 && !en) m_on = 1'b0;
            m_pos = (m_pos + 1) % FT;
        end else if (en) begin
            m_on  = 1'b1;
            m_pos = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
        nrdy = m_on && ((m_pos % HT) < HA) && ((m_pos / HT) < VA);
        exp_vec = {rdy, e_fs, ~e_vs, ~e_hs, 2'b00, 2'b00, 12'(h), 12'(v), e_rgb, m_uf, nrdy};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0;
        pif.i_pix_valid = 1'b0; pif.i_pix_rgb = 24'd0;
        m_on = 1'b0; m_pos = 0; m_uf = 1'b0; exp_vec = RST_VEC;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (obs() !== exp_vec) $display("FAIL reset_hold: got %h want %h", obs(), exp_vec); else passes++;
        checks++; if (o_cb !== 2'b11) $display("FAIL reset_ctrl_b: got %b want 11", o_cb); else passes++;
        #2 rst_n = 1'b1;
        tick();
        checks++; if (obs() !== exp_vec) $display("FAIL idle_after_release: got %h want %h", obs(), exp_vec); else passes++;
        en = 1'b1;
        tick();
        checks++; if (pif.o_pix_ready !== 1'b1) $display("FAIL first_ready: got %b want 1", pif.o_pix_ready); else passes++;
        checks++; if (obs() !== exp_vec) $display("FAIL enable_cycle: got %h want %h", obs(), exp_vec); else passes++;
        tick();
        checks++; if (o_fs !== 1'b1) $display("FAIL first_frame_start: got %b want 1", o_fs); else passes++;
    endtask

    task automatic test_full_frame();
        int xfers = 0, ves = 0, last_fs = -1, bad = 0;
        en = 1'b1; clr = 1'b0;
        for (int n = 0; n < 2 * FT; n++) begin
            pif.i_pix_valid = 1'b1;
            pif.i_pix_rgb   = 24'($urandom);
            if (pif.o_pix_ready && pif.i_pix_valid) xfers++;
            tick();
            if (o_ve) ves++;
            if (obs() !== exp_vec) begin
                bad++;
                if (bad < 4) $display("FAIL frame_cycle %0d: got %h want %h", n, obs(), exp_vec);
            end
            if (o_fs) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs !== FT) $display("FAIL frame_period: got %0d want %0d", cyc - last_fs, FT);
                    else passes++;
                end
                last_fs = cyc;
            end
        end
        checks++; if (bad != 0) $display("FAIL frame_outputs: got %0d bad cycles want 0", bad); else passes++;
        checks++; if (xfers != 2 * HA * VA) $display("FAIL frame_transfers: got %0d want %0d", xfers, 2 * HA * VA); else passes++;
        checks++; if (ves != 2 * HA * VA) $display("FAIL frame_ve_cycles: got %0d want %0d", ves, 2 * HA * VA); else passes++;
    endtask

    task automatic test_underflow();
        int n, bad = 0;
        en = 1'b1; pif.i_pix_valid = 1'b1; clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (o_uf !== 1'b0) $display("FAIL uf_initial_clear: got %b want 0", o_uf); else passes++;
        n = 0;
        while (exp_vec[0] !== 1'b1 && n < 100) begin tick(); n++; end
        pif.i_pix_valid = 1'b0;
        tick();
        pif.i_pix_valid = 1'b1;
        checks++;
        if ({o_ve, o_uf, o_r, o_g, o_b} !== {2'b11, 24'd0})
            $display("FAIL uf_zero_pixel: got ve=%b uf=%b rgb=%h want ve=1 uf=1 rgb=000000", o_ve, o_uf, {o_r, o_g, o_b});
        else passes++;
        repeat (3) tick();
        checks++; if (o_uf !== 1'b1) $display("FAIL uf_sticky: got %b want 1", o_uf); else passes++;
        n = 0;
        while (exp_vec[0] !== 1'b1 && n < 100) begin tick(); n++; end
        pif.i_pix_valid = 1'b0; clr = 1'b1;
        tick();
        checks++; if (o_uf !== 1'b1) $display("FAIL uf_set_wins: got %b want 1", o_uf); else passes++;
        pif.i_pix_valid = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (o_uf !== 1'b0) $display("FAIL uf_clear_alone: got %b want 0", o_uf); else passes++;
        for (int k = 0; k < 3 * FT; k++) begin
            pif.i_pix_valid = ($urandom % 4) != 0;
            pif.i_pix_rgb   = 24'($urandom);
            clr             = ($urandom % 8) == 0;
            tick();
            if (obs() !== exp_vec) begin
                bad++;
                if (bad < 4) $display("FAIL uf_random %0d: got %h want %h", k, obs(), exp_vec);
            end
        end
        clr = 1'b0; pif.i_pix_valid = 1'b1;
        checks++; if (bad != 0) $display("FAIL uf_random_total: got %0d bad cycles want 0", bad); else passes++;
    endtask

    task automatic test_stop_midframe();
        int n = 0, seen = 0, bad = 0;
        en = 1'b1; pif.i_pix_valid = 1'b1;
        while (!(m_on && m_pos == 2 * HT + 2 - HT) && n < 100) begin tick(); n++; end
        en = 1'b0;
        n = 0;
        while (m_on && n < 100) begin
            pif.i_pix_rgb = 24'($urandom);
            tick();
            n++;
            if (o_x == 12'(HT - 1) && o_y == 12'(VT - 1)) seen++;
            if (obs() !== exp_vec) begin
                bad++;
                if (bad < 4) $display("FAIL drain_cycle %0d: got %h want %h", n, obs(), exp_vec);
            end
        end
        checks++; if (n != FT - (HT + 2)) $display("FAIL drain_length: got %0d want %0d", n, FT - (HT + 2)); else passes++;
        checks++; if (seen != 1) $display("FAIL drain_last_position: got %0d want 1", seen); else passes++;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (obs() !== exp_vec || o_ve !== 1'b0 || pif.o_pix_ready !== 1'b0) begin
                bad++;
                if (bad < 4) $display("FAIL idle_cycle %0d: got %h want %h", k, obs(), exp_vec);
            end
        end
        checks++; if (bad != 0) $display("FAIL stop_total: got %0d bad cycles want 0", bad); else passes++;
    endtask

    task automatic test_reenable_drain();
        int first = -1, gap = -1, bad = 0;
        bit dropped = 1'b0;
        en = 1'b1; pif.i_pix_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (m_on && m_pos == HT + 2 && !dropped) begin en = 1'b0; dropped = 1'b1; end
            else if (dropped && m_on && m_pos == 2 * HT + 5 && !en) en = 1'b1;
            pif.i_pix_rgb = 24'($urandom);
            tick();
            if (obs() !== exp_vec) begin
                bad++;
                if (bad < 4) $display("FAIL reenable_cycle %0d: got %h want %h", n, obs(), exp_vec);
            end
            if (o_fs) begin
                if (first < 0) first = cyc;
                else begin gap = cyc - first; break; end
            end
        end
        checks++; if (gap != FT) $display("FAIL reenable_frame_gap: got %0d want %0d", gap, FT); else passes++;
        checks++; if (bad != 0) $display("FAIL reenable_total: got %0d bad cycles want 0", bad); else passes++;
    endtask

    task automatic test_async_reset();
        int n = 0;
        en = 1'b1; pif.i_pix_valid = 1'b1; pif.i_pix_rgb = 24'hA5C33C;
        while (!(m_on && m_pos == 2) && n < 100) begin tick(); n++; end
        tick();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (obs() !== RST_VEC) $display("FAIL async_reset_immediate: got %h want %h", obs(), RST_VEC); else passes++;
        m_on = 1'b0; m_pos = 0; m_uf = 1'b0; exp_vec = RST_VEC;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        checks++; if (pif.o_pix_ready !== 1'b1 || obs() !== exp_vec)
            $display("FAIL restart_ready: got %h want %h", obs(), exp_vec); else passes++;
        tick();
        checks++; if ({o_x, o_y, o_fs} !== {24'd0, 1'b1})
            $display("FAIL restart_origin: got x=%0d y=%0d fs=%b want x=0 y=0 fs=1", o_x, o_y, o_fs); else passes++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_underflow();
        test_stop_midframe();
        test_reenable_drain();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tmds_video_sequencer.md
# tmds_video_sequencer

Raster-timing controller that sequences the three TMDS encoder channels of the DVI/HDMI transmitter. It generates the horizontal and vertical counters, sync and video-enable, and a pixel-request handshake toward the frame source. It presents per-channel 8-bit data and 2-bit control words, cycle-aligned, to the red, green and blue encoders. It sits between the pixel source (pattern generator or framebuffer reader) and the encoders, in the pixel clock domain.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- i_clk  in  1  pixel clock; the only clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  start/continue raster generation
- i_pix_valid  in  1  source has a pixel on i_pix_rgb
- i_pix_rgb  in  24  {R,G,B} pixel
- i_clr_underflow  in  1  clears o_underflow
- o_pix_ready  out  1  sequencer consumes a pixel this cycle
- o_x, o_y  out  12 each  raster position of the registered outputs
- o_frame_start  out  1  one-cycle pulse aligned with position (0,0)
- o_ve  out  1  video enable to all three encoders
- o_red, o_green, o_blue  out  8 each  encoder data
- o_ctrl_b  out  2  {vs,hs} to the blue encoder
- o_ctrl_g, o_ctrl_r  out  2 each  held at 2'b00
- o_underflow  out  1  sticky: source missed a requested pixel

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL likewise. Both must be ≤ 4096. Counters are 12-bit and wrap to 0 at TOTAL-1.
- Counter h_cnt increments every RUN/DRAIN cycle. v_cnt increments when h_cnt wraps.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync is active for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. It depends on v_cnt only.
- States:
  - IDLE: counters held at 0, o_pix_ready=0, o_ve=0, sync inactive.
  - RUN: counters advance.
  - DRAIN: counters advance to finish the current frame.
- Transitions:
  - IDLE→RUN when i_enable=1. The first RUN cycle has counters at (0,0).
  - RUN→DRAIN when i_enable=0.
  - DRAIN→RUN when i_enable=1. Counters are not disturbed.
  - DRAIN→IDLE after the cycle with counters at (H_TOTAL-1, V_TOTAL-1).
  - RUN with i_enable=0 at (H_TOTAL-1, V_TOTAL-1) goes directly to IDLE.
- o_pix_ready = (state≠IDLE) AND active region. This is combinational from registered state and counters. A transfer occurs when o_pix_ready AND i_pix_valid.
- If o_pix_ready=1 and i_pix_valid=0, the pixel is output as 0x000000 and o_underflow is set. The raster never stalls.
- o_underflow is cleared by i_clr_underflow. If set and clear occur in the same cycle, set wins.
- i_pix_valid outside the active region is ignored; nothing is consumed.
- o_ctrl_b = {vs,hs}, each driven at its polarity (active → POL, inactive → ~POL).
- While o_ve=0, o_red/o_green/o_blue are 0.

## Timing
- Reset values:
  - State is IDLE and counters are 0.
  - o_pix_ready, o_ve, o_frame_start and o_underflow are 0.
  - o_x, o_y and all data outputs are 0.
  - o_ctrl_b = {~VS_POL,~HS_POL}, which is 2'b11 at defaults. o_ctrl_g and o_ctrl_r are 2'b00.
- All outputs except o_pix_ready are registered with 1-cycle latency from the counter position.
- A pixel accepted in cycle N appears on o_red/o_green/o_blue in cycle N+1, with o_ve=1 and o_x/o_y equal to its position.
- o_frame_start is high in the cycle where o_x=0, o_y=0 and the sequencer is not IDLE.
- Entering IDLE: on the cycle after the last frame cycle, outputs show blanking (o_ve=0, sync inactive).
- Asynchronous reset mid-frame forces the reset values immediately. Operation resumes at (0,0) only after i_rst_n is high and i_enable=1.

## Test plan
Test parameters: H 4/1/2/1 (H_TOTAL 8), V 2/1/1/1 (V_TOTAL 5), with default polarities.

- **Reset:** hold i_rst_n=0 -> o_ctrl_b=2'b11, o_ve=0 and o_pix_ready=0. Raise i_enable one cycle after reset release -> o_pix_ready=1 on the next cycle, and o_frame_start=1 one cycle later.
- **Full frame:** i_enable=1, i_pix_valid=1, i_pix_rgb = counter values.
  - Exactly 8 pixels are accepted per frame.
  - o_ve is high 4 cycles per active line.
  - hs=0 at h_cnt 5-6 and vs=0 on line 3.
  - The frame period is 40 cycles.
  - Output data equals the input delayed by 1 cycle.
- **Underflow:** drop i_pix_valid for one active cycle -> that pixel outputs 0x000000 and o_underflow=1 sticks. Assert i_clr_underflow together with a new underflow -> o_underflow stays 1. Assert i_clr_underflow alone -> it clears.
- **Stop mid-frame:** drop i_enable at (2,1) -> the frame completes through (7,4), then the sequencer goes IDLE with o_ve=0 and no further o_pix_ready.
- **Re-enable in DRAIN:** drop i_enable at (2,1) and re-raise it at (5,2) -> counters never reset, and the next frame starts with o_frame_start at 40 cycles after the previous one.
- **Asynchronous reset mid-line:** pulse i_rst_n=0 mid-line -> outputs return to reset values in the same cycle, without waiting for an i_clk edge. With i_enable=1, the raster restarts at (0,0) on the first cycle after release.
